// File: rtl/pyrite_bpi_flash_seq.sv
// pyrite_bpi_flash_seq
//   Sequences single asynchronous BPI (parallel NOR) flash read/write cycles
//   as SETUP -> PULSE -> HOLD, with per-command programmable phase lengths.
//
//   Optional feature macro: PYRITE_BPI_SEQ_POLL_EN
//     When defined, a write issued with cmd_poll=1 is followed by status
//     read cycles at the same address until dq[7]=1 or cfg_poll_max reads.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_*               command request (valid/ready), address {region,addr}
//   cfg_*               phase lengths minus one, poll read limit
//   rsp_valid           one-cycle completion strobe; rsp_rdata/rsp_error
//                       hold until the next strobe
//   busy                sequencer not idle
//   flash_*             flash pins (strobes active low)
//
// Handshake: a command transfers on the rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only while idle (and out of reset),
// including the cycle in which rsp_valid is asserted, so a held cmd_valid
// starts the next command with no idle gap. Responses have no backpressure.
module pyrite_bpi_flash_seq #(
    parameter int FLASH_DATA_W = 16,
    parameter int FLASH_ADDR_W = 23,
    parameter int FLASH_RGN_W  = 1,
    parameter int TIMING_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic                            cmd_poll,
    input  logic [FLASH_RGN_W+FLASH_ADDR_W-1:0] cmd_addr,
    input  logic [FLASH_DATA_W-1:0]         cmd_wdata,
    input  logic [TIMING_W-1:0]             cfg_setup,
    input  logic [TIMING_W-1:0]             cfg_pulse,
    input  logic [TIMING_W-1:0]             cfg_hold,
    input  logic [15:0]                     cfg_poll_max,
    output logic                            rsp_valid,
    output logic [FLASH_DATA_W-1:0]         rsp_rdata,
    output logic                            rsp_error,
    output logic                            busy,
    input  logic [FLASH_DATA_W-1:0]         flash_dq_i,
    output logic [FLASH_DATA_W-1:0]         flash_dq_o,
    output logic                            flash_dq_oe,
    output logic [FLASH_ADDR_W-1:0]         flash_addr,
    output logic [FLASH_RGN_W-1:0]          flash_region,
    output logic                            flash_region_oe,
    output logic                            flash_ce_n,
    output logic                            flash_oe_n,
    output logic                            flash_we_n,
    output logic                            flash_adv_n
);

    localparam int CMD_AW = FLASH_RGN_W + FLASH_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_POLL_GAP
    } state_t;

    state_t                 state_q, state_d;
    logic                   rdy_en_q;
    logic                   write_q;
    logic [CMD_AW-1:0]      addr_q;
    logic [FLASH_DATA_W-1:0] wdata_q;
    logic [TIMING_W-1:0]    setup_q, pulse_q, hold_q;
    logic [TIMING_W-1:0]    cnt_q;
    logic [FLASH_DATA_W-1:0] cap_q;
    logic                   rsp_valid_q;
    logic [FLASH_DATA_W-1:0] rsp_rdata_q;
    logic                   rsp_error_q;

    logic accept, phase_last, reading, poll_continue, poll_fail;

`ifdef PYRITE_BPI_SEQ_POLL_EN
    logic        poll_q;     // write requested status polling
    logic        polling_q;  // current cycle is a status read
    logic [15:0] poll_cnt_q; // status reads completed before this one
    logic [15:0] poll_max_q;

    assign reading = !write_q || polling_q;
    // Evaluated in HOLD: the write cycle always continues into polling; a
    // status read continues only while dq[7]=0 and the read limit remains.
    assign poll_continue = poll_q && (!polling_q ||
        (!cap_q[7] && ({1'b0, poll_cnt_q} + 17'd1 < {1'b0, poll_max_q})));
    assign poll_fail = polling_q && !cap_q[7];
`else
    logic unused_poll;
    assign unused_poll   = &{1'b0, cmd_poll, cfg_poll_max};
    assign reading       = !write_q;
    assign poll_continue = 1'b0;
    assign poll_fail     = 1'b0;
`endif

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        phase_last = 1'b1;
        case (state_q)
            S_SETUP: phase_last = (cnt_q == setup_q);
            S_PULSE: phase_last = (cnt_q == pulse_q);
            S_HOLD:  phase_last = (cnt_q == hold_q);
            default: phase_last = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_SETUP;
            S_SETUP:    if (phase_last) state_d = S_PULSE;
            S_PULSE:    if (phase_last) state_d = S_HOLD;
            S_HOLD:     if (phase_last) state_d = poll_continue ? S_POLL_GAP : S_IDLE;
            S_POLL_GAP: state_d = S_SETUP;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rdy_en_q    <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            setup_q     <= '0;
            pulse_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (state_d != state_q) cnt_q <= '0;
            else if (state_q != S_IDLE) cnt_q <= cnt_q + 1'b1;
            if (accept) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                setup_q <= cfg_setup;
                pulse_q <= cfg_pulse;
                hold_q  <= cfg_hold;
            end
            if (state_q == S_PULSE && phase_last && reading) cap_q <= flash_dq_i;
            if (state_q == S_HOLD && phase_last && !poll_continue) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= reading ? cap_q : '0;
                rsp_error_q <= poll_fail;
            end
        end
    end

`ifdef PYRITE_BPI_SEQ_POLL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_q     <= 1'b0;
            polling_q  <= 1'b0;
            poll_cnt_q <= '0;
            poll_max_q <= '0;
        end else if (accept) begin
            poll_q     <= cmd_write && cmd_poll;
            polling_q  <= 1'b0;
            poll_cnt_q <= '0;
            poll_max_q <= cfg_poll_max;
        end else if (state_q == S_HOLD && phase_last && poll_continue) begin
            polling_q <= 1'b1;
            if (polling_q) poll_cnt_q <= poll_cnt_q + 16'd1;
        end
    end
`endif

    logic active;
    assign active = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);

    assign cmd_ready       = (state_q == S_IDLE) && rdy_en_q;
    assign busy            = (state_q != S_IDLE);
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_error       = rsp_error_q;
    assign flash_dq_o      = wdata_q;
    assign flash_dq_oe     = active && !reading;
    assign flash_addr      = addr_q[FLASH_ADDR_W-1:0];
    assign flash_region    = addr_q[CMD_AW-1:FLASH_ADDR_W];
    assign flash_region_oe = active;
    assign flash_ce_n      = !active;
    assign flash_adv_n     = (state_q != S_SETUP);
    assign flash_oe_n      = !((state_q == S_PULSE) && reading);
    assign flash_we_n      = !((state_q == S_PULSE) && !reading);

endmodule
